// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl - instruction sequencer for the TOY core.
//
// Fetches 16-bit instructions over a req/ack memory port, decodes them,
// drives the register-file read/write ports, sequences the shared ALU
// (registered inputs, 1-cycle result) and resolves branches, jumps,
// loads, stores and halt.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-low reset
//   start_i                    start at PC_RESET (only from IDLE or HALT)
//   halted_o, pc_o             halt status, current PC
//   mem_req_o/we_o/addr_o/wdata_o, mem_rdata_i, mem_ack_i
//                              memory handshake port
//   rf_ra_o, rf_rb_o, rf_rdata_a_i, rf_rdata_b_i
//                              combinational register-file reads
//   rf_we_o, rf_wa_o, rf_wdata_o
//                              register-file write (1-cycle strobe)
//   alu_op_o, alu_a_o, alu_b_o, alu_c_i
//                              ALU operands and result
//   retired_o                  retired-instruction counter, present only
//                              when CORE_SEQ_CTRL_PERF_EN is defined
module core_seq_ctrl #(
    parameter int             AW       = 8,
    parameter int             DW       = 16,
    parameter logic [AW-1:0]  PC_RESET = 8'h10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          halted_o,
    output logic [AW-1:0] pc_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i,
    output logic [3:0]    rf_ra_o,
    output logic [3:0]    rf_rb_o,
    input  logic [DW-1:0] rf_rdata_a_i,
    input  logic [DW-1:0] rf_rdata_b_i,
    output logic          rf_we_o,
    output logic [3:0]    rf_wa_o,
    output logic [DW-1:0] rf_wdata_o,
    output logic [2:0]    alu_op_o,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    input  logic [DW-1:0] alu_c_i
`ifdef CORE_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]   retired_o
`endif
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, WB, MEM, HALT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mwdata_q, mwdata_d;

    logic [3:0] op, fd, fs, ft;
    logic [7:0] faddr;
    logic       rd_sel;
    logic       rf_span;

    assign op    = ir_q[15:12];
    assign fd    = ir_q[11:8];
    assign fs    = ir_q[7:4];
    assign ft    = ir_q[3:0];
    assign faddr = ir_q[7:0];

    // Port A reads R[d] for ops that consume it. Op B is included because its
    // store data is R[d] and its source field s is otherwise unused.
    assign rd_sel  = (op == 4'h9) || (op == 4'hB) || (op == 4'hC) ||
                     (op == 4'hD) || (op == 4'hE);
    assign rf_span = (state_q == DECODE) || (state_q == EXEC) ||
                     (state_q == WB) || (state_q == MEM);

    assign rf_ra_o  = rf_span ? (rd_sel ? fd : fs) : 4'h0;
    assign rf_rb_o  = rf_span ? ft : 4'h0;
    assign halted_o = (state_q == HALT);
    assign pc_o     = pc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            pc_q     <= PC_RESET;
            ir_q     <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        maddr_d     = maddr_q;
        mwdata_d    = mwdata_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rf_we_o     = 1'b0;
        rf_wa_o     = '0;
        rf_wdata_o  = '0;
        alu_op_o    = '0;
        alu_a_o     = '0;
        alu_b_o     = '0;

        case (state_q)
            IDLE, HALT: begin
                if (start_i) begin
                    pc_d    = PC_RESET;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_q;
                if (mem_ack_i) begin
                    ir_d    = mem_rdata_i;
                    pc_d    = pc_q + AW'(1);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (op)
                    4'h0: state_d = HALT;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_d = EXEC;
                    4'h8, 4'h9: begin
                        // Address and store data are captured here so they
                        // stay stable for the whole memory handshake.
                        maddr_d  = AW'(faddr);
                        mwdata_d = (op == 4'h9) ? rf_rdata_a_i : '0;
                        state_d  = MEM;
                    end
                    4'hA, 4'hB: begin
                        maddr_d  = AW'(rf_rdata_b_i[7:0]);
                        mwdata_d = (op == 4'hB) ? rf_rdata_a_i : '0;
                        state_d  = MEM;
                    end
                    4'hC: begin
                        if (rf_rdata_a_i == '0) pc_d = AW'(faddr);
                        state_d = FETCH;
                    end
                    4'hD: begin
                        if (!rf_rdata_a_i[DW-1] && (rf_rdata_a_i != '0))
                            pc_d = AW'(faddr);
                        state_d = FETCH;
                    end
                    4'hE: begin
                        pc_d    = AW'(rf_rdata_a_i[7:0]);
                        state_d = FETCH;
                    end
                    default: begin
                        // Jump-and-link: pc_q already points past this word.
                        rf_we_o    = (fd != 4'h0);
                        rf_wa_o    = fd;
                        rf_wdata_o = DW'(pc_q);
                        pc_d       = AW'(faddr);
                        state_d    = FETCH;
                    end
                endcase
            end
            EXEC: begin
                alu_op_o = (op == 4'h7) ? 3'd7 : (op[2:0] - 3'd1);
                alu_a_o  = rf_rdata_a_i;
                alu_b_o  = (op == 4'h7) ? DW'(faddr) : rf_rdata_b_i;
                state_d  = WB;
            end
            WB: begin
                rf_we_o    = (fd != 4'h0);
                rf_wa_o    = fd;
                rf_wdata_o = alu_c_i;
                state_d    = FETCH;
            end
            MEM: begin
                mem_req_o   = 1'b1;
                mem_we_o    = op[0];
                mem_addr_o  = maddr_q;
                mem_wdata_o = mwdata_q;
                if (mem_ack_i) begin
                    if (!op[0]) begin
                        rf_we_o    = (fd != 4'h0);
                        rf_wa_o    = fd;
                        rf_wdata_o = mem_rdata_i;
                    end
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CORE_SEQ_CTRL_PERF_EN
    logic retire;
    assign retire = (state_q == WB) ||
                    ((state_q == MEM) && mem_ack_i) ||
                    ((state_q == DECODE) && (op >= 4'hC));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)      retired_o <= '0;
        else if (retire) retired_o <= retired_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl - directed self-checking bench for core_seq_ctrl.
// Provides a memory model with programmable ack delay, a 16-entry register
// file and a registered-input ALU around the sequencer, then runs short
// hand-written programs and compares against hand-computed values.
module tb_core_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halted;
    logic [7:0]  pc;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [3:0]  rf_ra, rf_rb, rf_wa;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_c;
`ifdef CORE_SEQ_CTRL_PERF_EN
    logic [31:0] retired;
`endif

    always #5 clk = ~clk;

    core_seq_ctrl #(.AW(8), .DW(16), .PC_RESET(8'h10)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .halted_o(halted), .pc_o(pc),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .rf_ra_o(rf_ra), .rf_rb_o(rf_rb), .rf_rdata_a_i(rf_rdata_a),
        .rf_rdata_b_i(rf_rdata_b), .rf_we_o(rf_we), .rf_wa_o(rf_wa),
        .rf_wdata_o(rf_wdata), .alu_op_o(alu_op), .alu_a_o(alu_a),
        .alu_b_o(alu_b), .alu_c_i(alu_c)
`ifdef CORE_SEQ_CTRL_PERF_EN
        , .retired_o(retired)
`endif
    );

    // ---------------- memory model ----------------
    logic [15:0] mem [256];
    int unsigned wcnt = 0;
    int unsigned ack_dly = 0;
    logic        mem_clr, ld_en;
    logic [7:0]  ld_a;
    logic [15:0] ld_d;

    assign mem_ack   = mem_req && (wcnt == ack_dly);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_a] <= ld_d;
        end else if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    // ---------------- register file model ----------------
    logic [15:0] rf [16];
    logic        rf_clr;
    int          we_cnt = 0;

    assign rf_rdata_a = rf[rf_ra];
    assign rf_rdata_b = rf[rf_rb];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (rf_we && rf_wa != 4'h0) begin
            rf[rf_wa] <= rf_wdata;
        end
        if (rf_we) we_cnt <= we_cnt + 1;
    end

    // ---------------- ALU model (registered inputs) ----------------
    logic [2:0]  aop_q;
    logic [15:0] aa_q, ab_q;

    always @(posedge clk) begin
        aop_q <= alu_op;
        aa_q  <= alu_a;
        ab_q  <= alu_b;
    end

    always_comb begin
        alu_c = '0;
        case (aop_q)
            3'd0:    alu_c = aa_q + ab_q;
            3'd1:    alu_c = aa_q - ab_q;
            3'd2:    alu_c = aa_q & ab_q;
            3'd3:    alu_c = aa_q ^ ab_q;
            3'd4:    alu_c = aa_q << ab_q[3:0];
            3'd5:    alu_c = aa_q >> ab_q[3:0];
            3'd6:    alu_c = aa_q;
            default: alu_c = ab_q;
        endcase
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        ld_a  = a;
        ld_d  = d;
        ld_en = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic clear_rf();
        rf_clr = 1'b1;
        @(posedge clk);
        #1 rf_clr = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where FETCH is visible.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [7:0] a, input logic w,
                            input int max, output int n);
        n = 0;
        while (!(mem_req && mem_addr == a && mem_we == w) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, {31'b0, (mem_req && mem_addr == a && mem_we == w)}, 32'd1);
    endtask

    task automatic wait_we(input string tag, input int max, output int n);
        n = 0;
        while (!rf_we && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, {31'b0, rf_we}, 32'd1);
    endtask

    task automatic wait_halt(input string tag, input int max);
        int n;
        n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, {31'b0, halted}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        rst_n = 1'b0; start = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
        mem_clr = 1'b1; rf_clr = 1'b1;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0; rf_clr = 1'b0;

        // ---- 1: reset state ----
        check("rst_pc", pc, 32'h10);
        check("rst_req", mem_req, 0);
        check("rst_we", {mem_we, rf_we}, 0);
        check("rst_halt", halted, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        poke(8'h10, 16'h7A05);
        poke(8'h11, 16'h7B03);
        poke(8'h12, 16'h1CAB);
        poke(8'h13, 16'h0000);
        @(negedge clk);
        check("idle_req", mem_req, 0);
        pulse_start();
        check("start_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h10});

        // ---- 2: ALU program ----
        wait_we("a_we", 8, n);
        check("a_wr", {rf_wa, rf_wdata}, {4'hA, 16'h0005});
        @(negedge clk);
        wait_we("b_we", 8, n);
        check("b_wr", {rf_wa, rf_wdata}, {4'hB, 16'h0003});
        @(negedge clk);
        wait_req("f12", 8'h12, 1'b0, 8, n);
        // Fetch request cycle counts as the first of the four cycles.
        wait_we("c_we", 8, n);
        check("alu_lat", n, 3);
        check("c_wr", {rf_wa, rf_wdata}, {4'hC, 16'h0008});
        wait_halt("halt1", 10);
        check("halt1_pc", pc, 32'h14);
        @(negedge clk);
        check("halt1_noreq", {halted, mem_req, pc}, {1'b1, 1'b0, 8'h14});

        // ---- 3: store with delayed ack, then load ----
        poke(8'h10, 16'h9C20);
        poke(8'h11, 16'h8D20);
        poke(8'h12, 16'h0000);
        ack_dly = 3;
        @(negedge clk);
        pulse_start();
        wait_req("st", 8'h20, 1'b1, 20, n);
        for (int i = 0; i < 4; i++) begin
            check("st_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                  {1'b1, 1'b1, 8'h20, 16'h0008});
            @(negedge clk);
        end
        check("st_next", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h11});
        check("st_mem", mem[8'h20], 32'h0008);
        wait_we("ld_we", 30, n);
        check("ld_wr", {rf_wa, rf_wdata}, {4'hD, 16'h0008});
        wait_halt("halt2", 30);
        check("halt2_pc", pc, 32'h13);

        // ---- 4: conditional branches ----
        clear_rf();
        ack_dly = 0;
        poke(8'h10, 16'hCD40);
        poke(8'h40, 16'h7D80);
        poke(8'h41, 16'h7E08);
        poke(8'h42, 16'h5DDE);
        poke(8'h43, 16'hDD50);
        poke(8'h44, 16'h7D01);
        poke(8'h45, 16'hDD50);
        poke(8'h50, 16'h0000);
        @(negedge clk);
        pulse_start();
        wait_req("cz_tk", 8'h40, 1'b0, 3, n);
        check("cz_lat", n, 2);
        wait_we("d80_we", 8, n);
        check("d80_wr", {rf_wa, rf_wdata}, {4'hD, 16'h0080});
        @(negedge clk);
        wait_we("e8_we", 8, n);
        check("e8_wr", {rf_wa, rf_wdata}, {4'hE, 16'h0008});
        @(negedge clk);
        wait_we("shl_we", 8, n);
        check("shl_wr", {rf_wa, rf_wdata}, {4'hD, 16'h8000});
        @(negedge clk);
        wait_req("dn_nt", 8'h44, 1'b0, 4, n);
        check("dn_lat", n, 2);
        wait_we("d1_we", 8, n);
        check("d1_wr", {rf_wa, rf_wdata}, {4'hD, 16'h0001});
        @(negedge clk);
        wait_req("dp_tk", 8'h50, 1'b0, 6, n);
        wait_halt("halt3", 6);
        check("halt3_pc", pc, 32'h51);

        // ---- 5/6: R0 writes suppressed, jump-and-link, jump register ----
        poke(8'h10, 16'h1012);
        poke(8'h11, 16'h1012);
        poke(8'h12, 16'h1012);
        poke(8'h13, 16'h1012);
        poke(8'h14, 16'hFE30);
        poke(8'h15, 16'h0000);
        poke(8'h30, 16'hEE00);
        @(negedge clk);
        pulse_start();
        base = we_cnt;
        wait_we("jal_we", 30, n);
        check("jal_wr", {rf_wa, rf_wdata}, {4'hE, 16'h0015});
        @(negedge clk);
        wait_req("jal_tgt", 8'h30, 1'b0, 3, n);
        wait_req("jr_tgt", 8'h15, 1'b0, 4, n);
        wait_halt("halt4", 6);
        check("halt4_pc", pc, 32'h16);
        check("r0_we_cnt", we_cnt - base, 1);

        // ---- 6: async reset in the middle of a memory wait ----
        poke(8'h10, 16'h8D20);
        ack_dly = 10;
        @(negedge clk);
        pulse_start();
        wait_req("rw_mem", 8'h20, 1'b0, 30, n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", {mem_req, rf_we}, 0);
        check("arst_pc", pc, 32'h10);
        @(negedge clk);
        rst_n = 1'b1;
        ack_dly = 0;
        repeat (3) @(negedge clk);
        check("arst_idle", {halted, mem_req}, 0);

        // ---- 6: start ignored while running ----
        poke(8'h10, 16'h7101);
        poke(8'h11, 16'h7202);
        poke(8'h12, 16'h7303);
        poke(8'h13, 16'h0000);
        @(negedge clk);
        base = we_cnt;
        pulse_start();
        wait_req("sr_f11", 8'h11, 1'b0, 8, n);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_halt("halt5", 40);
        check("halt5_pc", pc, 32'h14);
        check("sr_we_cnt", we_cnt - base, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
